// File: rtl/s27_pkg.sv
// Shared definitions for the s27 channel array: per-channel state layout
// and the s27 next-state/output equations.
package s27_pkg;

  localparam int unsigned STATE_BITS = 3;

  typedef struct packed {
    logic g5;
    logic g6;
    logic g7;
  } s27_state_t;

  typedef struct packed {
    s27_state_t nxt;
    logic       g17;
  } s27_result_t;

  function automatic s27_result_t s27_next(
    input s27_state_t s,
    input logic       g0,
    input logic       g1,
    input logic       g2,
    input logic       g3
  );
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    s27_result_t r;
    g14   = ~g0;
    g8    = g14 & s.g6;
    g12   = ~(g1 | s.g7);
    g15   = g12 | g8;
    g16   = g3 | g8;
    g9    = ~(g15 & g16);
    g11   = ~(s.g5 | g9);
    g10   = ~(g14 | g11);
    g13   = ~(g2 | g12);
    r.nxt = '{g5: g10, g6: g11, g7: g13};
    r.g17 = ~g11;
    return r;
  endfunction

endpackage

// File: rtl/s27_core.sv
// One s27 channel: next-state/output logic plus three enabled mux-D scan flops
// shifting si -> G5 -> G6 -> G7 -> so.
module s27_core
  import s27_pkg::*;
(
  input  logic ck_i,
  input  logic rn_i,
  input  logic g0_i,
  input  logic g1_i,
  input  logic g2_i,
  input  logic g3_i,
  input  logic en_i,
  input  logic se_i,
  input  logic si_i,
  output logic g17_o,
  output logic so_o,
  output logic chg_o
);

  s27_state_t  state_q, state_d;
  s27_result_t res;

  always_comb begin
    res     = s27_next(state_q, g0_i, g1_i, g2_i, g3_i);
    state_d = state_q;
    if (se_i) begin
      state_d = '{g5: si_i, g6: state_q.g5, g7: state_q.g6};
    end else if (en_i) begin
      state_d = res.nxt;
    end
  end

  always_ff @(posedge ck_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Activity only counts functional updates that actually alter the state.
  assign chg_o = ~se_i & en_i & (res.nxt != state_q);
  assign g17_o = res.g17;
  assign so_o  = state_q.g7;

endmodule

// File: rtl/s27_array.sv
// CHANNELS independent s27 cores on one scan chain, optional G17 output
// register and a saturating activity counter.
module s27_array
  import s27_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned ACT_W    = 8
) (
  input  logic                CK,
  input  logic                RN,
  input  logic [CHANNELS-1:0] G0,
  input  logic [CHANNELS-1:0] G1,
  input  logic [CHANNELS-1:0] G2,
  input  logic [CHANNELS-1:0] G3,
  input  logic [CHANNELS-1:0] EN,
  input  logic                SE,
  input  logic                SI,
  input  logic                CLR,
  output logic [CHANNELS-1:0] G17,
  output logic                SO,
  output logic [ACT_W-1:0]    ACT
);

  logic [CHANNELS-1:0] chain_so;
  logic [CHANNELS-1:0] g17_c;
  logic [CHANNELS-1:0] chg;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic scan_in;
    if (i == 0) begin : g_head
      assign scan_in = SI;
    end else begin : g_link
      assign scan_in = chain_so[i-1];
    end

    s27_core u_core (
      .ck_i  (CK),
      .rn_i  (RN),
      .g0_i  (G0[i]),
      .g1_i  (G1[i]),
      .g2_i  (G2[i]),
      .g3_i  (G3[i]),
      .en_i  (EN[i]),
      .se_i  (SE),
      .si_i  (scan_in),
      .g17_o (g17_c[i]),
      .so_o  (chain_so[i]),
      .chg_o (chg[i])
    );
  end

  assign SO = chain_so[CHANNELS-1];

  if (OUT_REG != 0) begin : g_oreg
    logic [CHANNELS-1:0] g17_q;
    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        g17_q <= '0;
      end else begin
        g17_q <= g17_c;
      end
    end
    assign G17 = g17_q;
  end else begin : g_ocomb
    assign G17 = g17_c;
  end

  logic [ACT_W-1:0] act_q, act_d;

  always_comb begin
    act_d = act_q;
    if (CLR) begin
      act_d = '0;
    end else if ((|chg) && (act_q != '1)) begin
      act_d = act_q + {{(ACT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      act_q <= '0;
    end else begin
      act_q <= act_d;
    end
  end

  assign ACT = act_q;

endmodule

// File: tb/tb_s27_array.sv
// Directed bench for s27_array: one combinational-output instance (ACT_W=8)
// and one registered-output instance (ACT_W=2) driven by the same stimulus.
module tb_s27_array;

  logic       CK = 1'b0;
  logic       RN;
  logic [3:0] G0, G1, G2, G3, EN;
  logic       SE, SI, CLR;
  logic [3:0] G17a, G17b;
  logic       SOa, SOb;
  logic [7:0] ACTa;
  logic [1:0] ACTb;

  int checks   = 0;
  int failures = 0;

  always #5 CK = ~CK;

  s27_array #(.CHANNELS(4), .OUT_REG(0), .ACT_W(8)) dut_a (
    .CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .G3(G3), .EN(EN),
    .SE(SE), .SI(SI), .CLR(CLR), .G17(G17a), .SO(SOa), .ACT(ACTa)
  );

  s27_array #(.CHANNELS(4), .OUT_REG(1), .ACT_W(2)) dut_b (
    .CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .G3(G3), .EN(EN),
    .SE(SE), .SI(SI), .CLR(CLR), .G17(G17b), .SO(SOb), .ACT(ACTb)
  );

  // Chain-ordered state: bit 11 = ch0.G5 (first flop) ... bit 0 = ch3.G7 (SO)
  logic [11:0] st_all;
  logic [2:0]  st0;
  assign st_all = {dut_a.g_ch[0].u_core.state_q, dut_a.g_ch[1].u_core.state_q,
                   dut_a.g_ch[2].u_core.state_q, dut_a.g_ch[3].u_core.state_q};
  assign st0    = dut_a.g_ch[0].u_core.state_q;

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic clear_inputs;
    SE = 1'b0; CLR = 1'b0; SI = 1'b0; EN = '0;
    G0 = '0; G1 = '0; G2 = '0; G3 = '0;
  endtask

  task automatic do_reset;
    RN = 1'b0;
    clear_inputs();
    #1;
    tick();
    RN = 1'b1;
  endtask

  task automatic set_ch0(input logic a, input logic b, input logic c, input logic d);
    G0[0] = a; G1[0] = b; G2[0] = c; G3[0] = d;
  endtask

  task automatic test_reset;
    RN = 1'b0;
    clear_inputs();
    EN = '1;
    tick();
    tick();
    checks++; if (st_all !== 12'h000) begin failures++; $display("FAIL reset_state got=%h exp=000", st_all); end
    checks++; if (ACTa !== 8'd0) begin failures++; $display("FAIL reset_act_a got=%0d exp=0", ACTa); end
    checks++; if (ACTb !== 2'd0) begin failures++; $display("FAIL reset_act_b got=%0d exp=0", ACTb); end
    checks++; if (SOa !== 1'b0) begin failures++; $display("FAIL reset_so_a got=%b exp=0", SOa); end
    checks++; if (SOb !== 1'b0) begin failures++; $display("FAIL reset_so_b got=%b exp=0", SOb); end
    checks++; if (G17a !== 4'hF) begin failures++; $display("FAIL reset_g17_comb got=%h exp=f", G17a); end
    checks++; if (G17b !== 4'h0) begin failures++; $display("FAIL reset_g17_reg got=%h exp=0", G17b); end
    RN = 1'b1;
  endtask

  task automatic test_functional;
    do_reset();
    EN = 4'b0001;
    set_ch0(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (G17a[0] !== 1'b1) begin failures++; $display("FAIL func_g17 got=%b exp=1", G17a[0]); end
    tick();
    checks++; if (st0 !== 3'b101) begin failures++; $display("FAIL func_state got=%b exp=101", st0); end
    checks++; if (ACTa !== 8'd1) begin failures++; $display("FAIL func_act got=%0d exp=1", ACTa); end
    checks++; if (G17b !== 4'hF) begin failures++; $display("FAIL func_g17_reg got=%h exp=f", G17b); end
    tick();
    tick();
    checks++; if (st0 !== 3'b101) begin failures++; $display("FAIL func_hold got=%b exp=101", st0); end
    checks++; if (ACTa !== 8'd1) begin failures++; $display("FAIL func_act_hold got=%0d exp=1", ACTa); end
  endtask

  task automatic test_alt_path;
    do_reset();
    EN = 4'b0000;
    set_ch0(1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    checks++; if (G17a[0] !== 1'b0) begin failures++; $display("FAIL alt_g17 got=%b exp=0", G17a[0]); end
    tick();
    checks++; if (st0 !== 3'b000) begin failures++; $display("FAIL alt_en_off got=%b exp=000", st0); end
    checks++; if (ACTa !== 8'd0) begin failures++; $display("FAIL alt_act_off got=%0d exp=0", ACTa); end
    EN = 4'b0001;
    tick();
    checks++; if (st0 !== 3'b010) begin failures++; $display("FAIL alt_state got=%b exp=010", st0); end
    checks++; if (ACTa !== 8'd1) begin failures++; $display("FAIL alt_act got=%0d exp=1", ACTa); end
  endtask

  task automatic test_scan;
    logic [11:0] pat;
    pat = 12'b101100111000;
    do_reset();
    EN = '1;
    SE = 1'b1;
    for (int k = 0; k < 12; k++) begin
      SI = pat[k];
      tick();
    end
    checks++; if (st_all !== pat) begin failures++; $display("FAIL scan_load got=%h exp=%h", st_all, pat); end
    checks++; if (ACTa !== 8'd0) begin failures++; $display("FAIL scan_act_load got=%0d exp=0", ACTa); end
    SI = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (SOa !== pat[k]) begin failures++; $display("FAIL scan_so bit=%0d got=%b exp=%b", k, SOa, pat[k]); end
      tick();
    end
    checks++; if (st_all !== 12'h000) begin failures++; $display("FAIL scan_flush got=%h exp=000", st_all); end
    checks++; if (ACTa !== 8'd0) begin failures++; $display("FAIL scan_act_unload got=%0d exp=0", ACTa); end
    SE = 1'b0;
  endtask

  task automatic test_saturation;
    logic [1:0] expb;
    do_reset();
    EN = 4'b0001;
    // Alternating input sets toggle ch0 between 000 and 101 every edge.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) set_ch0(1'b1, 1'b1, 1'b0, 1'b1);
      else            set_ch0(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      expb = (k < 3) ? 2'(k + 1) : 2'd3;
      checks++; if (ACTb !== expb) begin failures++; $display("FAIL sat_act_b step=%0d got=%0d exp=%0d", k, ACTb, expb); end
      checks++; if (ACTa !== 8'(k + 1)) begin failures++; $display("FAIL sat_act_a step=%0d got=%0d exp=%0d", k, ACTa, k + 1); end
    end
    set_ch0(1'b1, 1'b1, 1'b0, 1'b1);
    CLR = 1'b1;
    tick();
    checks++; if (ACTb !== 2'd0) begin failures++; $display("FAIL clr_act_b got=%0d exp=0", ACTb); end
    checks++; if (ACTa !== 8'd0) begin failures++; $display("FAIL clr_act_a got=%0d exp=0", ACTa); end
    checks++; if (st0 !== 3'b101) begin failures++; $display("FAIL clr_state got=%b exp=101", st0); end
    CLR = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    EN = 4'b0001;
    set_ch0(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (ACTa !== 8'd1) begin failures++; $display("FAIL ar_pre_act got=%0d exp=1", ACTa); end
    G0 = '0; G1 = '0; G2 = '0; G3 = '0;
    SE = 1'b1;
    SI = 1'b1;
    tick();
    tick();
    checks++; if (G17b !== 4'hF) begin failures++; $display("FAIL ar_pre_g17_reg got=%h exp=f", G17b); end
    checks++; if (st_all === 12'h000) begin failures++; $display("FAIL ar_pre_state got=%h exp=nonzero", st_all); end
    #2;
    RN = 1'b0;
    #1;
    checks++; if (st_all !== 12'h000) begin failures++; $display("FAIL ar_state got=%h exp=000", st_all); end
    checks++; if (ACTa !== 8'd0) begin failures++; $display("FAIL ar_act_a got=%0d exp=0", ACTa); end
    checks++; if (ACTb !== 2'd0) begin failures++; $display("FAIL ar_act_b got=%0d exp=0", ACTb); end
    checks++; if (G17b !== 4'h0) begin failures++; $display("FAIL ar_g17_reg got=%h exp=0", G17b); end
    checks++; if (SOa !== 1'b0) begin failures++; $display("FAIL ar_so got=%b exp=0", SOa); end
    tick();
    RN = 1'b1;
    SE = 1'b0;
  endtask

  initial begin
    RN = 1'b0;
    clear_inputs();
    test_reset();
    test_functional();
    test_alt_path();
    test_scan();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s27_array.md
# s27_array

Parametrised multi-channel successor of the s27 sequential benchmark core for CCS timing characterisation. It instantiates CHANNELS independent copies of the s27 three-flop state machine with per-channel clock enable. A shared mux-D scan chain loads and unloads all state bits. A saturating activity counter counts functional cycles in which any state bit changed. It sits in the benchmark input set as a scalable sequential load for timing and noise experiments.

## Interface
Parameters:
- CHANNELS, 4: number of s27 channels (≥1).
- OUT_REG, 0: 1 = G17 outputs registered (one extra cycle latency); 0 = combinational.
- ACT_W, 8: activity counter width (≥2).

Ports:
- CK  in  1  clock, rising edge; the only clock.
- RN  in  1  reset, asynchronous, active-low.
- G0, G1, G2, G3  in  CHANNELS each  per-channel primary inputs, bit i → channel i.
- EN  in  CHANNELS  per-channel state update enable.
- SE  in  1  scan enable; overrides EN.
- SI  in  1  scan serial input.
- CLR  in  1  synchronous clear of the activity counter.
- G17  out  CHANNELS  per-channel primary output.
- SO  out  1  scan serial output.
- ACT  out  ACT_W  activity count.

## Operation
- Per-channel state is G5, G6, G7. Combinational logic per channel i:
  - G14 = ~G0; G8 = G14 & G6; G12 = ~(G1 | G7).
  - G15 = G12 | G8; G16 = G3 | G8; G9 = ~(G15 & G16).
  - G11 = ~(G5 | G9); G10 = ~(G14 | G11); G13 = ~(G2 | G12).
  - G17 = ~G11.
- Functional mode (SE=0): channel i with EN[i]=1 loads G5←G10, G6←G11, G7←G13. With EN[i]=0 it holds.
- Scan mode (SE=1): all channels shift regardless of EN. The chain order is SI→ch0.G5→ch0.G6→ch0.G7→ch1.G5→…→ch(CHANNELS-1).G7→SO. SO is that last flop's Q, unregistered beyond it. Chain length = 3·CHANNELS.
- OUT_REG=1: G17[i] is the registered combinational value, updated every cycle independent of EN and SE.
- Activity counter:
  - In a functional cycle (SE=0) where any enabled channel's next state differs from its current state, ACT increments by 1.
  - ACT saturates at 2^ACT_W−1.
  - CLR=1 forces ACT to 0 and wins over increment.
  - Scan cycles never count.

## Timing
- Reset (RN=0, async): all G5/G6/G7 = 0, ACT = 0, registered G17 = 0, SO = 0. Combinational G17 follows the inputs with state 0.
- Deassertion of RN is taken synchronously. The first state update occurs on the first rising CK edge with RN=1.
- State latency: 1 cycle. G17 latency: 0 cycles (OUT_REG=0) or 1 cycle (OUT_REG=1).
- SE switching takes effect on the same edge; no dead cycle.
- Reset asserted mid-scan discards the partial shift; all state reads 0.
- Simultaneous CLR and increment: result 0. Increment at saturation: hold.

## Structure
- Shared package s27_pkg:
  - constant STATE_BITS = 3.
  - struct s27_state_t {G5, G6, G7}.
  - function s27_next(state, G0..G3) returning next state and G17.
- One sub-module is natural: s27_core, a single-channel combinational next-state/output logic plus three enabled scan flops. It is generated CHANNELS times. The top level holds chain stitching, the output register and the activity counter.

## Test plan
- Reset check: RN=0 with any inputs → ACT=0, SO=0, all states 0. With G0..G3=0 on all channels → G17 all 1 (OUT_REG=0).
- Functional transition: from state 000, ch0 G0=1, G1=1, G2=0, G3=1, EN=1 → G17=1; next state (G5,G6,G7)=(1,0,1); state holds at 101 on further edges with the same inputs. ACT counts 1 then stays.
- Alternate path: from 000, G0=1, G1=0, G2=1, G3=1 → G17=0 combinationally; next state 010. With EN[0]=0 the state stays 000 and ACT is unchanged.
- Scan round-trip: CHANNELS=4, SE=1, shift 12-bit pattern 101100111000 LSB-first → after 12 edges state matches the pattern. A further 12 shifts return the same bits on SO in order. ACT unchanged throughout.
- Counter saturation/clear: ACT_W=2, force a state change every cycle → ACT reaches 3 and holds. CLR asserted on an incrementing cycle → ACT=0 next edge.
- Async reset mid-operation: assert RN low between edges during a scan shift → state, ACT and registered G17 clear immediately, without a clock edge.
